// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - pipelined immediate generator with prefix widening and one-entry output register
module immgen_pipe #(
  parameter int INSTR_W = 16,
  parameter int XLEN    = 16,
  parameter int PFX_W   = 10,
  parameter int I_W     = 6,
  parameter int B_W     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         fmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    imm,
  output logic               imm_prefixed,
  output logic               pfx_pending,
  output logic               pfx_overwrite
);

  // Working width large enough for any {prefix, field} combination plus the output width,
  // so sign extension happens once and truncation to XLEN is a plain slice.
  localparam int WW = PFX_W + B_W + XLEN;

  localparam logic [1:0] FMT_I   = 2'b00;
  localparam logic [1:0] FMT_U   = 2'b01;
  localparam logic [1:0] FMT_B   = 2'b10;
  localparam logic [1:0] FMT_PFX = 2'b11;

  logic [PFX_W-1:0] pfx_q;
  logic             accept;
  logic             is_pfx;
  logic [WW-1:0]    fi_s, fi_z, fb_s, fb_z, pfx_s, pfx_z;
  logic [WW-1:0]    wide;
  logic             unused_bits;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_pfx   = (fmt == FMT_PFX);

  // Field and prefix extensions; the prefix sits above the field, so its sign is the MSB of the combined value.
  assign fi_s  = {{(WW-I_W){instr[I_W-1]}}, instr[I_W-1:0]};
  assign fi_z  = {{(WW-I_W){1'b0}}, instr[I_W-1:0]};
  assign fb_s  = {{(WW-B_W){instr[B_W-1]}}, instr[B_W-1:0]};
  assign fb_z  = {{(WW-B_W){1'b0}}, instr[B_W-1:0]};
  assign pfx_s = {{(WW-PFX_W){pfx_q[PFX_W-1]}}, pfx_q};
  assign pfx_z = {{(WW-PFX_W){1'b0}}, pfx_q};

  // Select the extended immediate for the incoming instruction, widened by the pending prefix if any.
  always_comb begin
    wide = '0;
    case (fmt)
      FMT_I:   wide = pfx_pending ? ((pfx_s << I_W) | fi_z) : fi_s;
      FMT_U:   wide = pfx_pending ? ((pfx_z << I_W) | fi_z) : fi_z;
      FMT_B:   wide = pfx_pending ? ((pfx_s << B_W) | fb_z) : fb_s;
      default: wide = '0;
    endcase
  end

  assign unused_bits = ^{instr, wide[WW-1:XLEN]};

  // Output register, prefix state and overwrite pulse; flush outranks every handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      imm           <= '0;
      imm_prefixed  <= 1'b0;
      pfx_pending   <= 1'b0;
      pfx_overwrite <= 1'b0;
      pfx_q         <= '0;
    end else begin
      pfx_overwrite <= 1'b0;
      if (flush) begin
        out_valid    <= 1'b0;
        pfx_pending  <= 1'b0;
        imm_prefixed <= 1'b0;
      end else begin
        if (accept && !is_pfx) begin
          out_valid    <= 1'b1;
          imm          <= wide[XLEN-1:0];
          imm_prefixed <= pfx_pending;
          pfx_pending  <= 1'b0;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (accept && is_pfx) begin
          pfx_q         <= instr[PFX_W-1:0];
          pfx_pending   <= 1'b1;
          pfx_overwrite <= pfx_pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - self-checking bench for immgen_pipe
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr = '0;
  logic [1:0]  fmt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] imm;
  logic        imm_prefixed;
  logic        pfx_pending;
  logic        pfx_overwrite;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state
  bit          mv = 0, mip = 0, mpend = 0, movw = 0;
  logic [15:0] mimm = '0;
  logic [9:0]  mpval = '0;

  immgen_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .fmt(fmt), .out_valid(out_valid), .out_ready(out_ready), .imm(imm),
    .imm_prefixed(imm_prefixed), .pfx_pending(pfx_pending), .pfx_overwrite(pfx_overwrite)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate computed as an integer: value = prefix*2^FW + field, then two's-complement
  // interpretation over the combined width when signed, then the low 16 bits.
  function automatic logic [15:0] exp_imm(input logic [1:0] f, input logic [15:0] ins,
                                          input bit pre, input logic [9:0] pv);
    longint fw, fld, w, v;
    fw  = (f == 2'b10) ? 9 : 6;
    fld = longint'(ins) % (longint'(1) << fw);
    if (pre) begin
      v = longint'(pv) * (longint'(1) << fw) + fld;
      w = 10 + fw;
    end else begin
      v = fld;
      w = fw;
    end
    if (f != 2'b01 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v[15:0];
  endfunction

  function automatic bit m_ready();
    return !flush && (!mv || out_ready);
  endfunction

  // model update on each rising edge from the bench's own stimulus
  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      mv = 0; mimm = '0; mip = 0; mpend = 0; mpval = '0; movw = 0;
    end else begin
      acc  = in_valid && m_ready();
      movw = 0;
      if (flush) begin
        mv = 0; mpend = 0; mip = 0;
      end else if (acc && fmt == 2'b11) begin
        movw  = mpend;
        mpend = 1;
        mpval = instr[9:0];
        if (out_ready) mv = 0;
      end else if (acc) begin
        mimm  = exp_imm(fmt, instr, mpend, mpval);
        mip   = mpend;
        mpend = 0;
        mv    = 1;
      end else if (out_ready) begin
        mv = 0;
      end
    end
  end

  // compare DUT with model every cycle, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready", {15'd0, in_ready}, {15'd0, m_ready()});
      cmp("out_valid", {15'd0, out_valid}, {15'd0, mv});
      cmp("pfx_pending", {15'd0, pfx_pending}, {15'd0, mpend});
      cmp("pfx_overwrite", {15'd0, pfx_overwrite}, {15'd0, movw});
      cmp("imm_prefixed", {15'd0, imm_prefixed}, {15'd0, mip});
      if (mv) cmp("imm", imm, mimm);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [15:0] ins);
    in_valid = 1'b1;
    fmt      = f;
    instr    = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic lit_imm(input string name, input logic [15:0] e, input bit ep);
    @(negedge clk);
    cmp(name, imm, e);
    cmp({name, "_pfx"}, {15'd0, imm_prefixed}, {15'd0, ep});
    cmp({name, "_valid"}, {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    // reset
    step(); step();
    rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);
    cmp("rst_imm", imm, 16'h0000);
    cmp("rst_out_valid", {15'd0, out_valid}, 16'd0);
    cmp("rst_in_ready", {15'd0, in_ready}, 16'd1);

    // short formats
    drive(2'b00, 16'h003D); lit_imm("i_neg", 16'hFFFD, 0);
    drive(2'b01, 16'h003D); lit_imm("u_zext", 16'h003D, 0);
    drive(2'b10, 16'h01F0); lit_imm("b_neg", 16'hFFF0, 0);

    // prefix
    drive(2'b11, 16'h0001);
    @(negedge clk);
    cmp("pfx_set", {15'd0, pfx_pending}, 16'd1);
    cmp("pfx_no_out", {15'd0, out_valid}, 16'd0);
    drive(2'b00, 16'h0005); lit_imm("pfx_i", 16'h0045, 1);
    cmp("pfx_clr", {15'd0, pfx_pending}, 16'd0);
    drive(2'b11, 16'h03FF);
    drive(2'b00, 16'h003F); lit_imm("pfx_ones", 16'hFFFF, 1);

    // prefixed branch truncation
    drive(2'b11, 16'h02AB);
    drive(2'b10, 16'h00FF); lit_imm("pfx_b_trunc", 16'h56FF, 1);

    // backpressure then back-to-back stream
    out_ready = 1'b1; in_valid = 1'b1; fmt = 2'b00; instr = 16'h0001;
    step();
    out_ready = 1'b0; instr = 16'h0002;
    repeat (3) begin
      @(negedge clk);
      cmp("bp_in_ready", {15'd0, in_ready}, 16'd0);
      cmp("bp_imm_hold", imm, 16'h0001);
      step();
    end
    out_ready = 1'b1;
    step();
    for (int k = 3; k <= 6; k++) begin
      instr = 16'(k);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    cmp("stream_last", imm, 16'h0006);
    cmp("stream_valid", {15'd0, out_valid}, 16'd1);

    // flush of a held output entry
    drive(2'b00, 16'h0007);
    out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cmp("flush_out_valid", {15'd0, out_valid}, 16'd0);

    // flush of a pending prefix, with an instruction offered
    drive(2'b11, 16'h0001);
    flush = 1'b1; in_valid = 1'b1; fmt = 2'b00; instr = 16'h0005;
    @(negedge clk);
    cmp("flush_in_ready", {15'd0, in_ready}, 16'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    cmp("flush_pfx", {15'd0, pfx_pending}, 16'd0);
    drive(2'b00, 16'h0005); lit_imm("post_flush", 16'h0005, 0);

    // overwrite
    drive(2'b11, 16'h0001);
    drive(2'b11, 16'h0002);
    @(negedge clk);
    cmp("ovw_hi", {15'd0, pfx_overwrite}, 16'd1);
    step();
    @(negedge clk);
    cmp("ovw_lo", {15'd0, pfx_overwrite}, 16'd0);
    drive(2'b01, 16'h0000); lit_imm("ovw_u", 16'h0080, 1);

    // reset mid-stream loses the prefix
    drive(2'b00, 16'h0009);
    drive(2'b11, 16'h0005);
    rst_n = 1'b0; in_valid = 1'b1; fmt = 2'b00; instr = 16'h0003;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    cmp("mrst_valid", {15'd0, out_valid}, 16'd0);
    cmp("mrst_imm", imm, 16'h0000);
    cmp("mrst_pfx", {15'd0, pfx_pending}, 16'd0);
    cmp("mrst_in_ready", {15'd0, in_ready}, 16'd1);
    drive(2'b00, 16'h0005); lit_imm("mrst_after", 16'h0005, 0);

    step(); step();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
